vga_plot_sink: RTL and testbench

VGA_PLOT_SINK -- requirements
Module: vga_plot_sink

---
 rtl/vga_plot_sink.sv | 125 ++++++++++++
 tb/tb_vga_plot_sink.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_sink.sv
// vga_plot_sink: 3-bit framebuffer with a plot port, a self-running fill,
// sticky error flags and a registered readback port.
module vga_plot_sink #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  input  logic        clear,
  input  logic [2:0]  clear_colour,
  output logic        busy,
  input  logic [7:0]  rd_x,
  input  logic [6:0]  rd_y,
  output logic [2:0]  rd_colour,
  output logic [14:0] plot_count,
  output logic        oob_err,
  output logic        drop_err
);

  localparam int AW    = 15;
  localparam int DEPTH = WIDTH * HEIGHT;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [14:0] CMAX = '1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t state, state_nx;

  logic [AW-1:0] fill_addr;
  logic [AW-1:0] plot_addr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic [2:0]    fill_colour;
  logic [2:0]    wr_data;
  logic          wr_en;
  logic          plot_ok;
  logic          rd_ok;

  logic [2:0] mem [DEPTH];

  assign plot_ok = (int'(vga_x) < WIDTH) && (int'(vga_y) < HEIGHT);
  assign rd_ok   = (int'(rd_x) < WIDTH) && (int'(rd_y) < HEIGHT);

  assign plot_addr = AW'(vga_y) * AW'(WIDTH) + AW'(vga_x);
  assign rd_addr   = AW'(rd_y) * AW'(WIDTH) + AW'(rd_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR: if (fill_addr == LAST) state_nx = IDLE;
      IDLE:  if (clear) state_nx = CLEAR;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = plot_addr;
    wr_data = vga_colour;
    unique case (state)
      CLEAR: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = fill_addr;
        wr_data = fill_colour;
      end
      IDLE: wr_en = vga_plot && plot_ok;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_addr   <= '0;
      fill_colour <= '0;
    end else if (state == CLEAR) begin
      fill_addr <= (fill_addr == LAST) ? '0 : fill_addr + 1'b1;
    end else if (clear) begin
      fill_addr   <= '0;
      fill_colour <= clear_colour;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plot_count <= '0;
      oob_err    <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      if (state == IDLE && clear) begin
        plot_count <= '0;
      end else if (state == IDLE && vga_plot && plot_ok
                   && plot_count != CMAX) begin
        plot_count <= plot_count + 1'b1;
      end
      if (state == IDLE && vga_plot && !plot_ok) oob_err <= 1'b1;
      if (state == CLEAR && vga_plot) drop_err <= 1'b1;
    end
  end

  // Storage carries no reset; the post-reset fill initialises it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_colour <= '0;
    end else begin
      rd_colour <= rd_ok ? mem[rd_addr] : 3'd0;
    end
  end

endmodule

// File: tb/tb_vga_plot_sink.sv
// tb_vga_plot_sink: directed plus randomized checks of vga_plot_sink
// against a pixel-array reference model.
module tb_vga_plot_sink;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        clear;
  logic [2:0]  clear_colour;
  logic        busy;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic [2:0]  rd_colour;
  logic [14:0] plot_count;
  logic        oob_err;
  logic        drop_err;

  int tests = 0;
  int fails = 0;

  logic [2:0] fb [N];
  int m_count;
  bit m_oob;
  bit m_drop;

  always #5 clk = ~clk;

  vga_plot_sink #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot),
    .clear(clear), .clear_colour(clear_colour),
    .busy(busy), .rd_x(rd_x), .rd_y(rd_y),
    .rd_colour(rd_colour), .plot_count(plot_count),
    .oob_err(oob_err), .drop_err(drop_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [2:0] ref_rd(input int x, input int y);
    return (x < W && y < H) ? fb[y * W + x] : 3'd0;
  endfunction

  task automatic fill_ref(input logic [2:0] c);
    foreach (fb[i]) fb[i] = c;
  endtask

  task automatic status(input string tag);
    check({tag, "_count"}, 32'(plot_count), 32'(m_count));
    check({tag, "_oob"}, 32'(oob_err), 32'(m_oob));
    check({tag, "_drop"}, 32'(drop_err), 32'(m_drop));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // One idle cycle: optional plot plus a readback of (rx, ry).
  task automatic cycle(input int px, input int py,
                       input logic [2:0] pc, input bit p,
                       input int rx, input int ry);
    logic [2:0] exp;
    vga_x = 8'(px);
    vga_y = 7'(py);
    vga_colour = pc;
    vga_plot = p;
    rd_x = 8'(rx);
    rd_y = 7'(ry);
    exp = ref_rd(rx, ry);
    step();
    vga_plot = 1'b0;
    if (p) begin
      if (px < W && py < H) begin
        fb[py * W + px] = pc;
        if (m_count < 32767) m_count++;
      end else begin
        m_oob = 1'b1;
      end
    end
    check("rd", 32'(rd_colour), 32'(exp));
  endtask

  task automatic rd(input int x, input int y);
    cycle(0, 0, 3'd0, 1'b0, x, y);
  endtask

  task automatic wait_fill(input int start, input string tag);
    int n;
    n = start;
    while (busy === 1'b1 && n < 40000) begin
      step();
      n++;
    end
    check(tag, n, N);
  endtask

  initial begin
    int px, py, rx, ry;
    rst_n = 1'b0;
    vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
    clear = 1'b0; clear_colour = '0; rd_x = '0; rd_y = '0;
    m_count = 0; m_oob = 1'b0; m_drop = 1'b0;
    fill_ref(3'd0);

    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rd", 32'(rd_colour), 32'd0);
    check("rst_count", 32'(plot_count), 32'd0);
    check("rst_oob", 32'(oob_err), 32'd0);
    check("rst_drop", 32'(drop_err), 32'd0);

    rst_n = 1'b1;
    wait_fill(0, "init_fill");
    status("init");
    rd(0, 0);
    rd(159, 119);

    cycle(5, 7, 3'b101, 1'b1, 0, 0);
    rd(5, 7);
    status("plot1");

    cycle(160, 0, 3'd7, 1'b1, 0, 0);
    cycle(0, 120, 3'd7, 1'b1, 159, 119);
    rd(0, 0);
    rd(159, 119);
    status("oob");

    cycle(10, 10, 3'd3, 1'b1, 10, 10);
    rd(10, 10);

    repeat (400) begin
      px = $urandom_range(0, 175);
      py = $urandom_range(0, 127);
      if ($urandom_range(0, 1) == 1) begin
        rx = px;
        ry = py;
      end else begin
        rx = $urandom_range(0, 175);
        ry = $urandom_range(0, 127);
      end
      cycle(px, py, 3'($urandom), 1'($urandom), rx, ry);
      status("rand");
    end

    // Clear racing an in-range plot, then a dropped plot and ignored clear.
    clear = 1'b1; clear_colour = 3'b010;
    vga_x = 8'd0; vga_y = 7'd0; vga_colour = 3'd7; vga_plot = 1'b1;
    step();
    clear = 1'b0; vga_plot = 1'b0;
    m_count = 0;
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_count", 32'(plot_count), 32'd0);
    vga_x = 8'd1; vga_y = 7'd1; vga_colour = 3'd6; vga_plot = 1'b1;
    clear = 1'b1; clear_colour = 3'b101;
    step();
    vga_plot = 1'b0; clear = 1'b0;
    m_drop = 1'b1;
    wait_fill(1, "clr_fill");
    fill_ref(3'b010);
    status("clr");
    rd(0, 0);
    rd(80, 60);
    rd(1, 1);

    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'd4; vga_plot = 1'b1;
        step();
      end
    end
    vga_plot = 1'b0;
    fill_ref(3'd4);
    m_count = N;
    status("raster");
    repeat (20) rd($urandom_range(0, W - 1), $urandom_range(0, H - 1));
    rd(159, 119);

    clear = 1'b1; clear_colour = 3'd3;
    step();
    clear = 1'b0;
    repeat (100) step();
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd1);
    check("arst_rd", 32'(rd_colour), 32'd0);
    check("arst_count", 32'(plot_count), 32'd0);
    check("arst_oob", 32'(oob_err), 32'd0);
    check("arst_drop", 32'(drop_err), 32'd0);
    m_count = 0; m_oob = 1'b0; m_drop = 1'b0;
    step();
    rst_n = 1'b1;
    wait_fill(0, "arst_fill");
    fill_ref(3'd0);
    status("arst");
    rd(0, 0);
    rd(99, 0);
    rd(159, 119);
    repeat (20) rd($urandom_range(0, W - 1), $urandom_range(0, H - 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
